// File: rtl/uart_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer_pkg
// Description : Shared sizing defaults and handshake-FSM state encodings for
//               the UART receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_buffer_pkg;

    // Default FIFO geometry: entries and pointer width (log2 of entries)
    localparam int c_rxb_depth  = 16;
    localparam int c_rxb_addr_w = 4;

    // Receiver handshake FSM encodings; 2'b11 is unused and recovers to idle
    typedef logic [1:0] rxb_state_t;
    localparam rxb_state_t c_st_idle     = 2'd0;
    localparam rxb_state_t c_st_ack      = 2'd1;
    localparam rxb_state_t c_st_wait_clr = 2'd2;

endpackage : uart_rx_buffer_pkg
`default_nettype wire

// File: rtl/uart_rx_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rxb_fifo
// Description : Byte FIFO for the UART receive buffer. Holds storage,
//               wrapping pointers, an explicit occupancy counter and the
//               push/pop arbitration. Read side is first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module rxb_fifo
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = c_rxb_depth,
    parameter int ADDR_W = c_rxb_addr_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [7:0]        i_wdata,
    input  logic              i_pop,
    output logic [7:0]        o_rdata,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_push_ok
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    // Occupancy flags and arbitration: a full FIFO still accepts when a pop
    // frees the head slot on the same edge
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == c_depth);
        w_pop_ok  = i_pop && !w_empty;
        w_push_ok = i_push && (!w_full || w_pop_ok);
    end

    // Storage write; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head byte falls through; masked to zero so an empty read is benign
    always_comb begin
        o_rdata   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
        o_empty   = w_empty;
        o_full    = w_full;
        o_count   = r_count;
        o_push_ok = w_push_ok;
    end

endmodule : rxb_fifo
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer
// Description : Captures each byte announced by the UART receiver status into
//               a FIFO, returns a one-cycle registered clear pulse to the
//               receiver, and keeps a sticky overrun flag for dropped bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = c_rxb_depth,
    parameter int ADDR_W = c_rxb_addr_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rs,
    output logic              over_read,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overrun,
    input  logic              clr_overrun
);

    rxb_state_t r_state;
    rxb_state_t w_state_nxt;
    logic       r_rs_q;
    logic       r_over_read;
    logic       r_overrun;
    logic       w_push;
    logic       w_push_ok;

    // Single register stage on the receiver status; the FSM only sees r_rs_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_q <= 1'b0;
        end else begin
            r_rs_q <= rx_rs;
        end
    end

    // Handshake FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: push on status seen, one ACK cycle to cover the status lag,
    // then wait for the receiver to drop status before re-arming
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_rs_q) begin
                    w_push      = 1'b1;
                    w_state_nxt = c_st_ack;
                end
            end
            c_st_ack: begin
                w_state_nxt = c_st_wait_clr;
            end
            c_st_wait_clr: begin
                if (!r_rs_q) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Clear pulse is a plain flop so the receiver's async clear never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_over_read <= 1'b0;
        end else begin
            r_over_read <= w_push;
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_push && !w_push_ok) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    rxb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wdata   (rx_data),
        .i_pop     (rd_en),
        .o_rdata   (rd_data),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full),
        .o_count   (fifo_count),
        .o_push_ok (w_push_ok)
    );

    assign over_read = r_over_read;
    assign overrun   = r_overrun;

endmodule : uart_rx_buffer
`default_nettype wire
